alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit ALU control code from alu control, plus two operands, and produces a registered result with a valid/ready handshake on both sides.
- Single-cycle ops (add/sub/logic/compare) complete in one cycle.
- Shifts use an iterative one-bit-per-cycle shifter to save area.
- Sits between decode/operand-select and writeback.

Parameters:
XLEN, 32, operand/result width; shift counter width is $clog2(XLEN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands and op valid
in_ready  out  1  unit can accept this cycle
alu_ctrl  in  4  operation code (values in alu_pkg)
op_a  in  XLEN  operand A (shift source)
op_b  in  XLEN  operand B; bits [4:0] are the shift amount for shifts
flush  in  1  synchronous abort of in-flight op and pending result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  registered result
zero  out  1  registered (result == 0)
illegal  out  1  registered, set when alu_ctrl is not a defined code

Behaviour:
Op codes:
- AND 0011, OR 0101, ADD 0010, SUB 0110, SLL 0001, SRL 0100, SRA 1101, SLT 0111, SLTU 1100, XOR 0000.
- All others, including 1111, are illegal.

Reset (async, on assertion):
- state=IDLE; out_valid=0, result=0, zero=0, illegal=0; shift counter=0.
- in_ready=1 once reset deasserts.

Handshake rules:
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept on a clk edge with in_valid && in_ready.
- Output holds result/zero/illegal stable while out_valid && !out_ready.
- out_valid drops on the edge where out_ready=1, unless a new result is written on that same edge. Simultaneous drain+fill gives back-to-back valid.

States:
- IDLE.
  - Accept of a non-shift op, or a shift with shamt==0: result written on the accept edge, out_valid=1 next cycle (latency 1). Stay IDLE.
  - Accept of a shift with shamt=n>0: latch op_a into the shift register, count=n, kind (SLL/SRL/SRA). Go SHIFT; out_valid stays 0.
- SHIFT.
  - Each edge: shift one bit (SRA replicates bit XLEN-1; SRL/SLL fill 0), count--.
  - On the edge where count==1: write result/zero, set out_valid, go IDLE. Total latency = 1+n cycles (max 32).
  - in_ready=0 throughout.

Arithmetic:
- ADD/SUB modulo 2^XLEN, no overflow flag.
- SLT signed compare, SLTU unsigned; result is 32'h1 or 32'h0.
- op_b[XLEN-1:5] is ignored for shifts.

Illegal code:
- result=0, zero=1, illegal=1, latency 1.

Flush:
- Priority over accept and shift progress.
- Next edge: state=IDLE, out_valid=0, count=0.
- result/zero/illegal are unchanged but are don't-care.

Reset mid-shift:
- Aborts immediately; no result is produced.

Throughput:
- One non-shift op per cycle when out_ready stays 1.

Decomposition:
- alu_pkg: XLEN default, the ten op-code localparams plus ILLEGAL=4'b1111, and a state enum (IDLE, SHIFT).
- Sub-module alu_comb_core: purely combinational single-cycle ops (a, b, ctrl -> res, illegal). alu_exec_unit instantiates it and owns the handshake, FSM and iterative shifter.

Test Plan:
- ADD a=7, b=5, out_ready=1 -> next cycle out_valid=1, result=12, zero=0. SUB 5-5 -> result=0, zero=1.
- SLT a=32'hFFFF_FFFF, b=1 -> 1. SLTU same operands -> 0. XOR 32'hF0F0_F0F0 ^ 32'hFFFF_0000 -> 32'h0F0F_F0F0.
- SRA a=32'h8000_0000, b=4 -> in_ready=0 for 4 cycles, out_valid on cycle 5 after accept, result=32'hF800_0000. SLL b=0 -> 1-cycle latency, result=a. SRL b=31 of 32'h8000_0000 -> result=1 after 32 cycles.
- Backpressure: out_ready=0 with a result held -> in_ready=0, result stable ≥5 cycles. Raise out_ready while in_valid=1 -> drain+accept on the same edge, out_valid stays 1 with the new result.
- alu_ctrl=4'b1111 -> result=0, zero=1, illegal=1; following legal op clears illegal.
- Flush at count=3 during SLL by 10 -> no out_valid, IDLE next cycle. Async rst mid-shift -> all outputs 0 immediately, in_ready=1 after deassertion.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, state encodings and helpers for the execute-stage ALU.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [3:0] ALU_XOR     = 4'b0000;
  localparam logic [3:0] ALU_SLL     = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_AND     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_OR      = 4'b0101;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_SLTU    = 4'b1100;
  localparam logic [3:0] ALU_SRA     = 4'b1101;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_e;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_comb_core.sv
// Single-cycle ALU datapath; shift codes pass operand A through unchanged so
// a zero-amount shift can complete in one cycle using this result.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] res,
  output logic            illegal
);

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (ctrl)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLT:  res = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: res = XLEN'(a < b);
      ALU_SLL, ALU_SRL, ALU_SRA: res = a;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result with valid/ready on both sides and an
// iterative one-bit-per-cycle shifter.
//   state    | meaning
//   ST_IDLE  | accepting ops; single-cycle results written on accept edge
//   ST_SHIFT | shifting one bit per edge until count reaches 1
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  logic [0:0]      state_q, state_d;
  logic [SHW-1:0]  count_q, count_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  shift_kind_e     kind_q, kind_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;

  logic [XLEN-1:0] core_res;
  logic            core_illegal;
  logic [XLEN-1:0] shifted;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            start_shift;

  alu_comb_core #(.XLEN(XLEN)) u_core (
    .a       (op_a),
    .b       (op_b),
    .ctrl    (alu_ctrl),
    .res     (core_res),
    .illegal (core_illegal)
  );

  assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept      = in_valid && in_ready;
  assign shamt       = op_b[SHW-1:0];
  assign start_shift = is_shift_op(alu_ctrl) && (shamt != '0);

  always_comb begin
    case (kind_q)
      SK_SLL:  shifted = {shreg_q[XLEN-2:0], 1'b0};
      SK_SRL:  shifted = {1'b0, shreg_q[XLEN-1:1]};
      default: shifted = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    kind_d      = kind_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q && !out_ready;

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      count_d     = '0;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = shifted;
      count_d = count_q - SHW'(1);
      if (count_q == SHW'(1)) begin
        state_d     = ST_IDLE;
        result_d    = shifted;
        zero_d      = (shifted == '0);
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
      end
    end else if (accept) begin
      if (start_shift) begin
        state_d = ST_SHIFT;
        shreg_d = op_a;
        count_d = shamt;
        case (alu_ctrl)
          ALU_SLL: kind_d = SK_SLL;
          ALU_SRL: kind_d = SK_SRL;
          default: kind_d = SK_SRA;
        endcase
      end else begin
        result_d    = core_res;
        zero_d      = (core_res == '0);
        illegal_d   = core_illegal;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      kind_q      <= SK_SLL;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      kind_q      <= kind_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: whole-amount shifts, latency equals shift amount after accept edge.
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic il, output int lat);
    int sh;
    sh  = int'(b % 32);
    il  = 1'b0;
    lat = 0;
    case (c)
      4'b0011: r = a & b;
      4'b0101: r = a | b;
      4'b0000: r = a ^ b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = (a < b) ? 32'd1 : 32'd0;
      4'b0001: begin r = a << sh; lat = sh; end
      4'b0100: begin r = a >> sh; lat = sh; end
      4'b1101: begin r = 32'($signed(a) >>> sh); lat = sh; end
      default: begin r = 32'd0; il = 1'b1; end
    endcase
  endtask

  // Issue one op, hold the result under backpressure for `hold` cycles, then drain if asked.
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit drain);
    logic [31:0] er;
    logic        eil;
    int          elat;
    int          n;
    model(c, a, b, er, eil, elat);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("result", result, er);
    chk("zero", 32'(zero), 32'(er == 32'd0));
    chk("illegal", 32'(illegal), 32'(eil));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", result, er);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    if (drain) begin
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_valid", 32'(out_valid), 32'd0);
    end
  endtask

  logic [3:0] ns_ops [7] = '{4'b0011, 4'b0101, 4'b0000, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  initial begin
    logic [31:0] er, ra, rb;
    logic        eil;
    int          elat;
    logic [3:0]  rc;

    rst = 1'b1; in_valid = 1'b0; alu_ctrl = 4'd0; op_a = '0; op_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    do_op(4'b0010, 32'd7, 32'd5, 0, 1);
    do_op(4'b0110, 32'd5, 32'd5, 0, 1);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0, 1);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'd1, 0, 1);
    do_op(4'b0000, 32'hF0F0_F0F0, 32'hFFFF_0000, 0, 1);
    do_op(4'b1101, 32'h8000_0000, 32'd4, 0, 1);
    do_op(4'b0001, 32'h1234_5678, 32'd0, 0, 1);
    do_op(4'b0100, 32'h8000_0000, 32'd31, 0, 1);
    do_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1);
    do_op(4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 1);
    do_op(4'b1010, 32'd3, 32'd3, 1, 1);
    do_op(4'b0101, 32'hFFFF_FFE0, 32'h0000_0123, 6, 0);

    // drain and fill on the same edge
    model(4'b0010, 32'd100, 32'd23, er, eil, elat);
    alu_ctrl = 4'b0010; op_a = 32'd100; op_b = 32'd23;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("fill_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill_valid", 32'(out_valid), 32'd1);
    chk("fill_result", result, er);
    @(negedge clk);
    chk("fill_drain", 32'(out_valid), 32'd0);

    // back-to-back single-cycle throughput
    rc = ns_ops[$urandom_range(0, 6)]; ra = $urandom; rb = $urandom;
    alu_ctrl = rc; op_a = ra; op_b = rb; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      model(rc, ra, rb, er, eil, elat);
      @(negedge clk);
      chk("tput_valid", 32'(out_valid), 32'd1);
      chk("tput_result", result, er);
      chk("tput_in_ready", 32'(in_ready), 32'd1);
      rc = ns_ops[$urandom_range(0, 6)]; ra = $urandom; rb = $urandom;
      alu_ctrl = rc; op_a = ra; op_b = rb;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("tput_drain", 32'(out_valid), 32'd0);

    // flush during SLL by 10 when count reaches 3
    alu_ctrl = 4'b0001; op_a = 32'h0000_0001; op_b = 32'd10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_idle", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("flush_no_result", 32'(seen), 32'd0);
    end
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0, 1);

    // async reset in the middle of a shift
    alu_ctrl = 4'b0100; op_a = 32'hDEAD_BEEF; op_b = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_zero", 32'(zero), 32'd0);
    chk("arst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("arst_no_result", 32'(seen), 32'd0);
    end

    for (int t = 0; t < 40; t++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      do_op(rc, ra, rb, $urandom_range(0, 3), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
